bcd_serial_adder: RTL and testbench

//   Multi-digit BCD adder that sequences operands one digit per cycle, LSD first, through a

---
 rtl/bcd_serial_adder.sv | 97 +++++++++
 tb/tb_bcd_serial_adder.sv | 164 ++++++++++++++++
 2 files changed

// File: rtl/bcd_serial_adder.sv
// bcd_serial_adder: multi-digit BCD adder that runs one digit per cycle, LSD first, behind a start/busy/done handshake
module bcd_serial_adder #(
  parameter int DIGITS = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [4*DIGITS-1:0]   a,
  input  logic [4*DIGITS-1:0]   b,
  input  logic                  cin,
  output logic                  busy,
  output logic                  done,
  output logic [4*DIGITS-1:0]   sum,
  output logic                  cout,
  output logic                  invalid
);
  localparam int W = 4 * DIGITS;
  localparam int IW = DIGITS > 1 ? $clog2(DIGITS) : 1;
  typedef enum logic [1:0] {IDLE, ADD, DONE} state_t;
  state_t state_q, state_d;
  logic [W-1:0] opa_q, opa_d, opb_q, opb_d, res_q, res_d, sum_q, sum_d;
  logic [IW-1:0] idx_q, idx_d;
  logic c_q, c_d, inv_q, inv_d, cout_q, cout_d, invalid_q, invalid_d;
  logic [4:0] t;
  logic gt;
  logic [3:0] s;
  logic bad;
  always_comb begin
    t = {1'b0, opa_q[3:0]} + {1'b0, opb_q[3:0]} + {4'd0, c_q};
    gt = t > 5'd9;
    s = gt ? t[3:0] + 4'd6 : t[3:0];
    bad = 1'b0;
    for (int i = 0; i < DIGITS; i++) bad = bad | (a[4*i+:4] > 4'd9) | (b[4*i+:4] > 4'd9);
    state_d = state_q;
    opa_d = opa_q;
    opb_d = opb_q;
    res_d = res_q;
    sum_d = sum_q;
    idx_d = idx_q;
    c_d = c_q;
    inv_d = inv_q;
    cout_d = cout_q;
    invalid_d = invalid_q;
    if (state_q == ADD) begin
      opa_d = opa_q >> 4;
      opb_d = opb_q >> 4;
      c_d = gt;
      idx_d = idx_q + 1'b1;
      res_d = W'({s, res_q} >> 4);
      if (idx_q == IW'(DIGITS - 1)) begin
        state_d = DONE;
        sum_d = res_d;
        cout_d = gt;
        invalid_d = inv_q;
      end
    end else if (start) begin
      state_d = ADD;
      opa_d = a;
      opb_d = b;
      c_d = cin;
      idx_d = '0;
      inv_d = bad;
    end else begin
      state_d = IDLE;
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      opa_q <= '0;
      opb_q <= '0;
      res_q <= '0;
      sum_q <= '0;
      idx_q <= '0;
      c_q <= 1'b0;
      inv_q <= 1'b0;
      cout_q <= 1'b0;
      invalid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      opa_q <= opa_d;
      opb_q <= opb_d;
      res_q <= res_d;
      sum_q <= sum_d;
      idx_q <= idx_d;
      c_q <= c_d;
      inv_q <= inv_d;
      cout_q <= cout_d;
      invalid_q <= invalid_d;
    end
  end
  assign busy = state_q == ADD;
  assign done = state_q == DONE;
  assign sum = sum_q;
  assign cout = cout_q;
  assign invalid = invalid_q;
endmodule

// File: tb/tb_bcd_serial_adder.sv
// tb_bcd_serial_adder: randomized scoreboard bench for bcd_serial_adder against a digit-rule reference model
module tb_bcd_serial_adder;
  localparam int D = 4;
  typedef struct {
    int e;
    logic [15:0] s;
    logic co;
    logic inv;
  } exp_t;
  logic clk = 0, rst = 1, start = 0, cin = 0;
  logic [15:0] a = 0, b = 0;
  logic busy, done, cout, invalid;
  logic [15:0] sum;
  int cyc = 0, errors = 0, checks = 0;
  exp_t q[$];
  logic [15:0] last_s;
  logic last_co, last_inv;
  bcd_serial_adder #(.DIGITS(D)) dut (
    .clk(clk), .rst(rst), .start(start), .a(a), .b(b), .cin(cin),
    .busy(busy), .done(done), .sum(sum), .cout(cout), .invalid(invalid)
  );
  always #5 clk = ~clk;
  task automatic chk(input string n, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s at cycle %0d: got %0h expected %0h", n, cyc, act, req);
    end
  endtask
  function automatic exp_t ref_add(input int av, input int bv, input int c);
    exp_t r;
    int acc, x, y, t, p;
    acc = 0;
    p = 1;
    r.inv = 0;
    for (int i = 0; i < D; i++) begin
      x = (av / p) % 16;
      y = (bv / p) % 16;
      if (x > 9 || y > 9) r.inv = 1;
      t = x + y + c;
      c = t > 9 ? 1 : 0;
      acc = acc + (t > 9 ? (t + 6) % 16 : t) * p;
      p = p * 16;
    end
    r.s = 16'(acc);
    r.co = c[0];
    r.e = 0;
    return r;
  endfunction
  function automatic logic [15:0] rand_op(input bit allow_bad);
    int v, p;
    v = 0;
    p = 1;
    for (int i = 0; i < D; i++) begin
      v = v + ((allow_bad && $urandom_range(0, 7) == 0) ? $urandom_range(10, 15) : $urandom_range(0, 9)) * p;
      p = p * 16;
    end
    return 16'(v);
  endfunction
  task automatic drive(input logic [15:0] av, input logic [15:0] bv, input logic c, input bit accept);
    exp_t e;
    a = av;
    b = bv;
    cin = c;
    start = 1;
    if (accept) begin
      e = ref_add(int'(av), int'(bv), int'(c));
      e.e = cyc + 1;
      q.push_back(e);
    end
    @(negedge clk);
    start = 0;
    a = 16'($urandom);
    b = 16'($urandom);
    cin = 1'($urandom);
  endtask
  task automatic wait_idle();
    for (int k = 0; k < 60 && q.size() != 0; k++) @(negedge clk);
    chk("drain_timeout", q.size(), 0);
  endtask
  initial begin
    exp_t e;
    bit eb, ed;
    forever begin
      @(posedge clk);
      cyc++;
      #1;
      if (rst) begin
        q.delete();
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_sum", sum, 0);
        chk("rst_cout", cout, 0);
        chk("rst_invalid", invalid, 0);
        last_s = 0;
        last_co = 0;
        last_inv = 0;
      end else begin
        eb = q.size() > 0 && cyc >= q[0].e && cyc < q[0].e + D;
        ed = q.size() > 0 && cyc == q[0].e + D;
        chk("busy", busy, 32'(eb));
        chk("done", done, 32'(ed));
        if (ed) begin
          e = q.pop_front();
          chk("sum", sum, e.s);
          chk("cout", cout, e.co);
          chk("invalid", invalid, e.inv);
          last_s = e.s;
          last_co = e.co;
          last_inv = e.inv;
        end else begin
          chk("hold_sum", sum, last_s);
          chk("hold_cout", cout, last_co);
          chk("hold_invalid", invalid, last_inv);
        end
      end
    end
  end
  initial begin
    repeat (3) @(negedge clk);
    rst = 0;
    @(negedge clk);
    drive(16'h0999, 16'h0001, 0, 1);
    wait_idle();
    drive(16'h9999, 16'h0001, 0, 1);
    wait_idle();
    drive(16'h1234, 16'h5678, 1, 1);
    wait_idle();
    drive(16'h00A0, 16'h0000, 0, 1);
    wait_idle();
    @(negedge clk);
    drive(16'h4321, 16'h1111, 0, 1);
    @(negedge clk);
    drive(16'h0008, 16'h0008, 0, 0);
    repeat (D - 2) @(negedge clk);
    drive(16'h0008, 16'h0008, 0, 1);
    wait_idle();
    @(negedge clk);
    drive(16'h5555, 16'h5555, 1, 1);
    @(negedge clk);
    rst = 1;
    @(negedge clk);
    rst = 0;
    repeat (8) @(negedge clk);
    for (int n = 0; n < 40; n++) begin
      drive(rand_op(1), rand_op(1), 1'($urandom), 1);
      if ($urandom_range(0, 3) == 0) begin
        repeat (D) @(negedge clk);
      end else begin
        wait_idle();
        repeat ($urandom_range(0, 3)) @(negedge clk);
      end
    end
    wait_idle();
    repeat (3) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
  initial begin
    #200000;
    $display("FAIL global_timeout at cycle %0d", cyc);
    $fatal(1, "timeout");
  end
endmodule
